fetch_unit: RTL and testbench

Instruction fetch stage that owns the program counter and consumes the redirect (`jump`/`next`) produced by the EX-stage branch logic. It issues word-addressed requests to instruction memory over a request/ready plus response-valid handshake, buffers returned instructions in a 2-entry FIFO toward decode, and squashes in-flight and buffered fetches on every redirect. PC is a word address: sequential fetch adds 1, and branch targets arrive already word-scaled.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int FETCH_FIFO_DEPTH = 2;
  localparam int FETCH_XLEN       = 32;
  localparam logic [FETCH_XLEN-1:0] FETCH_RESET_PC = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] instr;
    logic [FETCH_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small register FIFO between fetch and decode; clear wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = FETCH_FIFO_DEPTH,
  parameter int  CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          push_i,
  input  entry_t        push_data_i,
  input  logic          pop_i,
  output entry_t        head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  entry_t        mem_q [DEPTH];
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i && !clear_i && (count_q != '0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_i && !clear_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches, squashes on redirect.
// Optional counters enabled with `define FETCH_PERF_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(FETCH_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            jump,
  input  logic [XLEN-1:0] next,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            flush
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushes
`endif
);

  localparam int CW = $clog2(FETCH_FIFO_DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            outstanding_q, outstanding_d;

  logic            handshake, credit, push, pop, fifo_empty;
  logic [CW-1:0]   fifo_count;
  entry_t          push_entry, head;

  assign credit    = (int'(fifo_count) + int'(outstanding_q)) < FETCH_FIFO_DEPTH;
  assign imem_req  = (state_q == REQ) && credit;
  assign imem_addr = pc_q;
  assign handshake = imem_req && imem_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    push          = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (handshake) begin
          outstanding_d = 1'b1;
          if (jump) begin
            state_d = DRAIN;
          end else begin
            req_pc_d = pc_q;
            pc_d     = pc_q + XLEN'(1);
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          push          = !jump;
          outstanding_d = 1'b0;
          state_d       = REQ;
        end else if (jump) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_rvalid) begin
          outstanding_d = 1'b0;
          state_d       = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    // A redirect overrides whatever PC the state logic chose, including the +1.
    if (jump) pc_d = next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign push_entry = '{instr: imem_rdata, pc: req_pc_q};
  assign pop        = if_valid && !stall;

  fetch_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FETCH_FIFO_DEPTH),
    .CW      (CW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (jump),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign if_valid = !fifo_empty && !jump;
  assign if_instr = head.instr;
  assign if_pc    = head.pc;
  assign flush    = jump;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_flushes_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (push) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (jump) perf_flushes_q <= perf_flushes_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, redirects, PC wrap, mid-transfer reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] next = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushes;
`endif

  int vectors = 0;
  int errors  = 0;

  logic        pend = 1'b0;
  logic [31:0] pend_data = '0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .jump        (jump),
    .next        (next),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .flush       (flush)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushes(perf_flushes)
`endif
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle memory: a request accepted this cycle answers on the next.
  task automatic mem_step(input logic rdy);
    logic        hs;
    logic [31:0] a;
    imem_ready  = rdy;
    imem_rvalid = pend;
    imem_rdata  = pend_data;
    #1;
    hs = imem_req && rdy;
    a  = imem_addr;
    @(posedge clk);
    #1;
    pend      = hs;
    pend_data = mdata(a);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; jump = 1'b0; next = '0; stall = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    pend = 1'b0; pend_data = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    vectors++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 00000000", imem_addr); end
    vectors++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", if_valid); end
    vectors++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 00000000", if_instr); end
    vectors++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 00000000", if_pc); end
    vectors++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b expected 0", flush); end
    $display("reset: outputs checked after reset release");
  endtask

  task automatic test_sequential();
    do_reset();
    mem_step(1'b1);  // IDLE cycle
    for (int i = 0; i < 10; i++) begin
      vectors++; if (imem_req !== (i % 2 == 0)) begin errors++; $display("FAIL seq_req[%0d]: got %b expected %b", i, imem_req, (i % 2 == 0)); end
      if (i % 2 == 0) begin
        vectors++; if (imem_addr !== 32'(i / 2)) begin errors++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, imem_addr, 32'(i / 2)); end
      end
      vectors++; if (if_valid !== (i >= 2 && i % 2 == 0)) begin errors++; $display("FAIL seq_valid[%0d]: got %b expected %b", i, if_valid, (i >= 2 && i % 2 == 0)); end
      if (i >= 2 && i % 2 == 0) begin
        vectors++; if (if_pc !== 32'((i - 2) / 2)) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, if_pc, 32'((i - 2) / 2)); end
        vectors++; if (if_instr !== mdata(32'((i - 2) / 2))) begin errors++; $display("FAIL seq_instr[%0d]: got %h expected %h", i, if_instr, mdata(32'((i - 2) / 2))); end
      end
      $display("seq cycle %0d: req=%b addr=%h valid=%b pc=%h", i, imem_req, imem_addr, if_valid, if_pc);
      mem_step(1'b1);
    end
  endtask

  task automatic test_stall();
    int exp_pc;
    logic seen_req;
    do_reset();
    stall = 1'b1;
    repeat (7) mem_step(1'b1);
    vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b expected 0", imem_req); end
    vectors++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", if_valid); end
    vectors++; if (if_pc !== 32'h0) begin errors++; $display("FAIL stall_pc: got %h expected 00000000", if_pc); end
    vectors++; if (if_instr !== mdata(32'h0)) begin errors++; $display("FAIL stall_instr: got %h expected %h", if_instr, mdata(32'h0)); end
    $display("stall: held pc=%h instr=%h req=%b", if_pc, if_instr, imem_req);
    stall = 1'b0;
    exp_pc = 0;
    seen_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (imem_req && !seen_req) begin
        seen_req = 1'b1;
        vectors++; if (imem_addr !== 32'h2) begin errors++; $display("FAIL stall_next_addr: got %h expected 00000002", imem_addr); end
      end
      if (if_valid) begin
        vectors++; if (if_pc !== 32'(exp_pc)) begin errors++; $display("FAIL stall_order: got %h expected %h", if_pc, 32'(exp_pc)); end
        exp_pc++;
      end
      mem_step(1'b1);
    end
    vectors++; if (exp_pc !== 5) begin errors++; $display("FAIL stall_pops: got %0d expected 5", exp_pc); end
    $display("stall release: %0d instructions delivered", exp_pc);
  endtask

  task automatic test_jump_wait();
    do_reset();
    imem_ready = 1'b1;
    tick(); tick();                      // REQ handshake -> WAIT
    jump = 1'b1; next = 32'h40;
    #1;
    vectors++; if (flush !== 1'b1) begin errors++; $display("FAIL jw_flush: got %b expected 1", flush); end
    tick();                              // WAIT + jump -> DRAIN
    jump = 1'b0;
    vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL jw_drain_req: got %b expected 0", imem_req); end
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD;
    tick();
    imem_rvalid = 1'b0;
    vectors++; if (if_valid !== 1'b0) begin errors++; $display("FAIL jw_valid: got %b expected 0", if_valid); end
    vectors++; if (if_instr === 32'hDEAD) begin errors++; $display("FAIL jw_stale: got %h required not 0000dead", if_instr); end
    vectors++; if (imem_req !== 1'b1) begin errors++; $display("FAIL jw_req: got %b expected 1", imem_req); end
    vectors++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL jw_addr: got %h expected 00000040", imem_addr); end
    tick();                              // 0x40 accepted -> WAIT
    jump = 1'b1; next = 32'h60; imem_rvalid = 1'b1; imem_rdata = 32'hBEEF;
    #1;
    vectors++; if (flush !== 1'b1) begin errors++; $display("FAIL jw2_flush: got %b expected 1", flush); end
    tick();
    jump = 1'b0; imem_rvalid = 1'b0;
    vectors++; if (if_valid !== 1'b0) begin errors++; $display("FAIL jw2_valid: got %b expected 0", if_valid); end
    vectors++; if (imem_addr !== 32'h60 || imem_req !== 1'b1) begin errors++; $display("FAIL jw2_addr: got req=%b addr=%h expected req=1 addr=00000060", imem_req, imem_addr); end
    $display("jump in WAIT: next request addr=%h", imem_addr);
  endtask

  task automatic test_jump_handshake();
    do_reset();
    tick();                              // REQ, memory not ready
    imem_ready = 1'b1; jump = 1'b1; next = 32'h80;
    #1;
    vectors++; if (flush !== 1'b1) begin errors++; $display("FAIL jh_flush: got %b expected 1", flush); end
    tick();
    jump = 1'b0;
    vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL jh_drain: got %b expected 0", imem_req); end
    imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
    tick();
    imem_rvalid = 1'b0;
    vectors++; if (if_valid !== 1'b0) begin errors++; $display("FAIL jh_valid: got %b expected 0", if_valid); end
    vectors++; if (imem_addr !== 32'h80 || imem_req !== 1'b1) begin errors++; $display("FAIL jh_addr: got req=%b addr=%h expected req=1 addr=00000080", imem_req, imem_addr); end
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h1111;
    tick();
    imem_rvalid = 1'b0;
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h80) begin errors++; $display("FAIL jh_pc: got valid=%b pc=%h expected valid=1 pc=00000080", if_valid, if_pc); end
    vectors++; if (if_instr !== 32'h1111) begin errors++; $display("FAIL jh_instr: got %h expected 00001111", if_instr); end
    $display("jump at handshake: delivered pc=%h instr=%h", if_pc, if_instr);
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    jump = 1'b1; next = 32'hFFFF_FFFF;
    tick();
    jump = 1'b0;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_first: got req=%b addr=%h expected req=1 addr=ffffffff", imem_req, imem_addr); end
    imem_ready = 1'b1;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h1234;
    tick();
    imem_rvalid = 1'b0;
    vectors++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 00000000", imem_addr); end
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_pc: got valid=%b pc=%h expected valid=1 pc=ffffffff", if_valid, if_pc); end
    $display("wrap: next addr=%h", imem_addr);
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_ready = 1'b1;
    tick(); tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h7777;
    tick();
    imem_rvalid = 1'b0; stall = 1'b1;
    tick();                              // second request outstanding, one entry buffered
    rst_n = 1'b0;
    #1;
    vectors++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0) begin errors++; $display("FAIL rmid_out: got valid=%b instr=%h pc=%h expected 0/0/0", if_valid, if_instr, if_pc); end
    vectors++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL rmid_req: got req=%b addr=%h expected req=0 addr=0", imem_req, imem_addr); end
    tick();
    rst_n = 1'b1; stall = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0;
    tick();
    imem_rvalid = 1'b0; imem_ready = 1'b0;
    tick();
    vectors++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rmid_late: got %b expected 0", if_valid); end
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rmid_first: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
    $display("reset mid-transfer: first addr=%h valid=%b", imem_addr, if_valid);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_jump_wait();
    test_jump_handshake();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
